frame_pixel_gen: RTL and testbench

//  Raster pixel source: drives the valid/data pixel-stream interface that frame statistics blocks (e.g. per-frame averager) consume.

---
 rtl/frame_pixel_gen_pkg.sv | 28 ++
 rtl/pix_lfsr8.sv | 24 ++
 rtl/frame_pixel_gen.sv | 146 ++++++++++++++
 tb/tb_frame_pixel_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_pixel_gen_pkg.sv
// rtl/frame_pixel_gen_pkg.sv - shared encodings and default frame geometry for the pixel source
package frame_pixel_gen_pkg;

  typedef enum logic [1:0] {
    PAT_CONST = 2'd0,
    PAT_HRAMP = 2'd1,
    PAT_VRAMP = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } gen_state_e;

  localparam int DEF_W      = 960;
  localparam int DEF_H      = 540;
  localparam int DEF_HBLANK = 4;
  localparam int DEF_VBLANK = 16;

  // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/pix_lfsr8.sv
// rtl/pix_lfsr8.sv - 8-bit maximal-length LFSR with seed load and step enable
module pix_lfsr8
  import frame_pixel_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] lfsr_q
);

  // an all-zero state would lock the register, so seed 0 becomes 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'h00;
    end else if (load) begin
      lfsr_q <= (seed == 8'h00) ? 8'h01 : seed;
    end else if (step) begin
      lfsr_q <= lfsr8_next(lfsr_q);
    end
  end

endmodule

// File: rtl/frame_pixel_gen.sv
// rtl/frame_pixel_gen.sv - raster pixel source with blanking, test patterns and per-frame sum
module frame_pixel_gen
  import frame_pixel_gen_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int H      = DEF_H,
  parameter int HBLANK = DEF_HBLANK,
  parameter int VBLANK = DEF_VBLANK
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_value,
  input  logic [7:0]  cfg_frames,
  output logic        valid,
  output logic [7:0]  data_out,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic        frame_done,
  output logic [27:0] frame_sum
);

  localparam logic [9:0]  X_LAST     = 10'(W - 1);
  localparam logic [9:0]  Y_LAST     = 10'(H - 1);
  localparam logic [15:0] HB_LAST    = 16'(HBLANK - 1);
  localparam logic [15:0] VB_LAST    = 16'(VBLANK - 1);
  localparam bit          HAS_HBLANK = (HBLANK != 0);

  gen_state_e  state_q, state_d;
  pat_mode_e   mode_q;
  logic [9:0]  x_q, y_q;
  logic [15:0] bl_q;
  logic        stop_pend_q;
  logic [7:0]  frame_cnt_q, frames_q, value_q;
  logic [7:0]  lfsr_q, pix;
  logic        lfsr_load, frames_met, in_blank;
  logic [27:0] acc_q, acc_next;

  assign frames_met = (frames_q != 8'd0) && (frame_cnt_q == frames_q);
  assign in_blank   = (state_q == ST_HBLANK) || (state_q == ST_VBLANK);
  assign lfsr_load  = ((state_q == ST_IDLE) && start) ||
                      ((state_q == ST_VBLANK) && (state_d == ST_ACTIVE));

  pix_lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .step   (state_q == ST_ACTIVE),
    .seed   ((state_q == ST_IDLE) ? cfg_value : value_q),
    .lfsr_q (lfsr_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST)   state_d = ST_VBLANK;
          else if (HAS_HBLANK) state_d = ST_HBLANK;
        end
      end
      ST_HBLANK: if (bl_q == HB_LAST) state_d = ST_ACTIVE;
      ST_VBLANK: begin
        if (bl_q == VB_LAST) state_d = (stop_pend_q || frames_met) ? ST_IDLE : ST_ACTIVE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= PAT_CONST;
      x_q         <= '0;
      y_q         <= '0;
      bl_q        <= '0;
      stop_pend_q <= 1'b0;
      frame_cnt_q <= '0;
      frames_q    <= '0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      bl_q        <= (in_blank && (state_d == state_q)) ? bl_q + 16'd1 : 16'd0;
      stop_pend_q <= (state_q == ST_IDLE) ? 1'b0 : (stop_pend_q | stop);
      if (state_q == ST_IDLE && start) begin
        mode_q      <= pat_mode_e'(cfg_mode);
        value_q     <= cfg_value;
        frames_q    <= cfg_frames;
        frame_cnt_q <= '0;
        x_q         <= '0;
        y_q         <= '0;
      end else if (state_q == ST_ACTIVE) begin
        x_q <= (x_q == X_LAST) ? 10'd0 : x_q + 10'd1;
        if (x_q == X_LAST) begin
          y_q <= (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
          if (y_q == Y_LAST) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    pix = value_q;
    case (mode_q)
      PAT_CONST: pix = value_q;
      PAT_HRAMP: pix = x_q[7:0] + value_q;
      PAT_VRAMP: pix = y_q[7:0] + value_q;
      PAT_LFSR:  pix = lfsr_q;
      default:   pix = value_q;
    endcase
  end

  // output stage runs one cycle behind the counters, so the sum closes on the eof beat
  assign acc_next = (sof ? 28'd0 : acc_q) + 28'(data_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      data_out   <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      acc_q      <= '0;
    end else begin
      valid      <= (state_q == ST_ACTIVE);
      data_out   <= pix;
      sof        <= (state_q == ST_ACTIVE) && (x_q == 10'd0) && (y_q == 10'd0);
      eol        <= (state_q == ST_ACTIVE) && (x_q == X_LAST);
      eof        <= (state_q == ST_ACTIVE) && (x_q == X_LAST) && (y_q == Y_LAST);
      busy       <= (state_d != ST_IDLE);
      frame_done <= valid && eof;
      if (valid) acc_q <= acc_next;
      if (valid && eof) frame_sum <= acc_next;
    end
  end

endmodule

// File: tb/tb_frame_pixel_gen.sv
// tb/tb_frame_pixel_gen.sv - scoreboard bench for frame_pixel_gen on a 16x16 frame
module tb_frame_pixel_gen;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int HB = 2;
  localparam int VB = 3;

  logic        clk, rst, start, stop;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_value, cfg_frames;
  logic        valid, sof, eol, eof, busy, frame_done;
  logic [7:0]  data_out;
  logic [27:0] frame_sum;

  typedef struct packed {
    logic [7:0]         d;
    logic               sof;
    logic               eol;
    logic               eof;
    logic signed [31:0] gap;
  } exp_t;

  exp_t        pix_q[$];
  logic [27:0] sum_q[$];
  int          n_cmp = 0, n_fail = 0, done_cnt = 0, idle_cnt = 0;
  bit          chk_en = 1'b1, prev_eof = 1'b0;

  frame_pixel_gen #(.W(W), .H(H), .HBLANK(HB), .VBLANK(VB)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_value(cfg_value), .cfg_frames(cfg_frames),
    .valid(valid), .data_out(data_out), .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .frame_done(frame_done), .frame_sum(frame_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [1:0] m, input logic [7:0] v, input bit first);
    logic [7:0] l;
    exp_t e;
    l = (v == 8'h00) ? 8'h01 : v;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (m)
          2'd0:    e.d = v;
          2'd1:    e.d = 8'(x) + v;
          2'd2:    e.d = 8'(y) + v;
          default: e.d = l;
        endcase
        l     = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        e.sof = (x == 0) && (y == 0);
        e.eol = (x == W - 1);
        e.eof = e.eol && (y == H - 1);
        e.gap = (x != 0) ? 0 : (y != 0) ? HB : first ? -1 : VB;
        pix_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      idle_cnt = 0;
      prev_eof = 1'b0;
    end else if (chk_en) begin
      if (valid) begin
        if (pix_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          e = pix_q.pop_front();
          check("pixel{data,sof,eol,eof}", {data_out, sof, eol, eof}, {e.d, e.sof, e.eol, e.eof});
          if (e.gap >= 0) check("idle_gap_before_pixel", idle_cnt, e.gap);
        end
        idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
      if (frame_done) begin
        check("frame_done_after_eof", prev_eof, 1);
        if (sum_q.size() == 0) check("unexpected_frame_done", 1, 0);
        else check("frame_sum", frame_sum, sum_q.pop_front());
        done_cnt++;
      end
      prev_eof = valid && eof;
    end
  end

  task automatic go(input logic [1:0] m, input logic [7:0] v, input logic [7:0] f, input logic with_stop);
    @(negedge clk);
    cfg_mode = m; cfg_value = v; cfg_frames = f; start = 1'b1; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_in_time"}, busy, 0);
    repeat (3) @(negedge clk);
    check({name, "_queues_drained"}, pix_q.size() + sum_q.size(), 0);
  endtask

  initial begin
    int base, n;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_mode = 2'd0; cfg_value = 8'h00; cfg_frames = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {valid, data_out, sof, eol, eof, busy, frame_done}, 0);
    check("reset_frame_sum", frame_sum, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // constant 0x80, one frame, with first-pixel latency check
    push_frame(2'd0, 8'h80, 1'b1);
    sum_q.push_back(28'd32768);
    go(2'd0, 8'h80, 8'd1, 1'b0);
    cfg_value = 8'h33;
    check("busy_after_start", busy, 1);
    check("valid_one_cycle_after_start", valid, 0);
    @(negedge clk);
    check("first_valid_with_sof", {valid, sof}, 2'b11);
    wait_idle("const80");

    // horizontal ramp offset 0x10, two frames
    push_frame(2'd1, 8'h10, 1'b1);
    push_frame(2'd1, 8'h10, 1'b0);
    sum_q.push_back(28'd6016);
    sum_q.push_back(28'd6016);
    go(2'd1, 8'h10, 8'd2, 1'b0);
    wait_idle("hramp");

    // vertical ramp wrapping past 0xFF; stop in the start cycle is ignored
    push_frame(2'd2, 8'hF8, 1'b1);
    push_frame(2'd2, 8'hF8, 1'b0);
    sum_q.push_back(28'd32640);
    sum_q.push_back(28'd32640);
    go(2'd2, 8'hF8, 8'd2, 1'b1);
    wait_idle("vramp_start_wins");

    // LFSR seed 0: 01,02,... 255 nonzero distinct values then 01 again
    push_frame(2'd3, 8'h00, 1'b1);
    sum_q.push_back(28'd32641);
    go(2'd3, 8'h00, 8'd1, 1'b0);
    wait_idle("lfsr_seed0");

    // continuous run, stop mid-line of frame 3, start while busy ignored
    push_frame(2'd0, 8'h05, 1'b1);
    push_frame(2'd0, 8'h05, 1'b0);
    push_frame(2'd0, 8'h05, 1'b0);
    repeat (3) sum_q.push_back(28'd1280);
    base = done_cnt;
    go(2'd0, 8'h05, 8'd0, 1'b0);
    n = 0;
    while (done_cnt < base + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("two_frames_before_stop", done_cnt - base, 2);
    repeat (20) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    go(2'd1, 8'h77, 8'd5, 1'b0);
    wait_idle("stop_mid_frame");
    check("frames_after_stop", done_cnt - base, 3);

    // asynchronous reset mid-line aborts with no frame_done
    chk_en = 1'b0;
    go(2'd0, 8'h09, 8'd0, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_line_valid_busy", {valid, busy}, 0);
    check("rst_mid_line_frame_done", frame_done, 0);
    check("rst_mid_line_frame_sum", frame_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_frame_done", frame_done, 0);
    chk_en = 1'b1;
    push_frame(2'd0, 8'h03, 1'b1);
    sum_q.push_back(28'd768);
    go(2'd0, 8'h03, 8'd1, 1'b0);
    wait_idle("fresh_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
